// File: rtl/lcd_hd44780_receiver_if.sv
// rtl/lcd_hd44780_receiver_if.sv - HD44780 4-bit LCD control-line bundle
//
// Purpose: groups the LCD bus lines seen by the receiver.
// Ports (signals):
//   iLCD_Enabled            E strobe
//   iLCD_RegisterSelect     0 = command, 1 = data
//   iLCD_StrataFlashControl 1 = LCD owns the shared bus
//   iLCD_ReadWrite          0 = write, 1 = read
//   iLCD_Data[3:0]          data nibble
// Modports: master drives the lines, slave (the receiver) samples them.
interface lcd_hd44780_receiver_if;
   logic       iLCD_Enabled;
   logic       iLCD_RegisterSelect;
   logic       iLCD_StrataFlashControl;
   logic       iLCD_ReadWrite;
   logic [3:0] iLCD_Data;

   modport master (
      output iLCD_Enabled,
      output iLCD_RegisterSelect,
      output iLCD_StrataFlashControl,
      output iLCD_ReadWrite,
      output iLCD_Data
   );

   modport slave (
      input iLCD_Enabled,
      input iLCD_RegisterSelect,
      input iLCD_StrataFlashControl,
      input iLCD_ReadWrite,
      input iLCD_Data
   );
endinterface

// File: rtl/lcd_hd44780_receiver.sv
// rtl/lcd_hd44780_receiver.sv - bus-functional HD44780 4-bit receiver
//
// Purpose: acts as the display controller at the far end of the LCD lines.
// Synchronizes the bus, runs the 4-bit init handshake, reassembles nibbles
// into bytes, decodes commands, tracks the DDRAM cursor and flags timing
// violations.
// Ports:
//   Clock          system clock
//   Reset          asynchronous active-low reset
//   lcd            LCD control lines (slave modport)
//   oInitDone      high once the init sequence 3,3,3,2 has been seen
//   oCommandValid  one-cycle pulse, oCommand valid
//   oCommand       last command byte
//   oDataValid     one-cycle pulse, oData valid
//   oData          last data byte
//   oCursorAddr    current DDRAM address
//   oErrorFlags    sticky: [0] short E, [1] gap violation, [2] read attempt
module lcd_hd44780_receiver #(
   parameter int MIN_E_HIGH     = 12,
   parameter int MIN_NIBBLE_GAP = 50,
   parameter int MIN_BYTE_GAP   = 2000,
   parameter int MIN_CLEAR_GAP  = 82000
) (
   input  logic                         Clock,
   input  logic                         Reset,
   lcd_hd44780_receiver_if.slave        lcd,
   output logic                         oInitDone,
   output logic                         oCommandValid,
   output logic [7:0]                   oCommand,
   output logic                         oDataValid,
   output logic [7:0]                   oData,
   output logic [6:0]                   oCursorAddr,
   output logic [2:0]                   oErrorFlags
);

   localparam int CW = 17;
   localparam logic [CW-1:0] CNT_MAX  = '1;
   localparam logic [CW-1:0] EHIGH_W  = CW'(MIN_E_HIGH);
   localparam logic [CW-1:0] NIBGAP_W = CW'(MIN_NIBBLE_GAP);
   localparam logic [CW-1:0] BYTE_W   = CW'(MIN_BYTE_GAP);
   localparam logic [CW-1:0] CLEAR_W  = CW'(MIN_CLEAR_GAP);

   typedef enum logic [2:0] {
      ST_INIT0 = 3'd0,
      ST_INIT1 = 3'd1,
      ST_INIT2 = 3'd2,
      ST_INIT3 = 3'd3,
      ST_HI    = 3'd4,
      ST_LO    = 3'd5
   } state_t;

   // Bus bit order in the synchronizer: {E, RS, SF, RW, D[3:0]}
   logic [7:0]    bus_in;
   logic [7:0]    sync1_q, sync1_d;
   logic [7:0]    sync2_q, sync2_d;
   logic          e_dly_q, e_dly_d;
   logic [CW-1:0] e_cnt_q, e_cnt_d;
   logic [CW-1:0] gap_cnt_q, gap_cnt_d;
   logic [CW-1:0] gap_req_q, gap_req_d;
   state_t        state_q, state_d;
   logic [3:0]    hi_nib_q, hi_nib_d;
   logic [3:0]    lo_nib_q, lo_nib_d;
   logic          rs_q, rs_d;
   logic          emit_q, emit_d;
   logic          inc_q, inc_d;
   logic [6:0]    cursor_q, cursor_d;
   logic [7:0]    cmd_q, cmd_d;
   logic [7:0]    data_q, data_d;
   logic          cmd_valid_q, cmd_valid_d;
   logic          data_valid_q, data_valid_d;
   logic [2:0]    err_q, err_d;
   logic          init_done_q, init_done_d;

   logic          s_e, s_rs, s_sf, s_rw;
   logic [3:0]    s_dat;
   logic          fall, strobe, wr_strobe;
   logic [7:0]    byte_w;

   assign bus_in = {lcd.iLCD_Enabled, lcd.iLCD_RegisterSelect,
                    lcd.iLCD_StrataFlashControl, lcd.iLCD_ReadWrite,
                    lcd.iLCD_Data};

   assign s_e    = sync2_q[7];
   assign s_rs   = sync2_q[6];
   assign s_sf   = sync2_q[5];
   assign s_rw   = sync2_q[4];
   assign s_dat  = sync2_q[3:0];

   assign fall      = e_dly_q & ~s_e;
   assign strobe    = fall & s_sf;
   assign wr_strobe = strobe & ~s_rw;
   assign byte_w    = {hi_nib_q, lo_nib_q};

   always_comb begin
      sync1_d      = bus_in;
      sync2_d      = sync1_q;
      e_dly_d      = s_e;
      e_cnt_d      = '0;
      gap_cnt_d    = (gap_cnt_q == CNT_MAX) ? gap_cnt_q : gap_cnt_q + 1'b1;
      gap_req_d    = gap_req_q;
      state_d      = state_q;
      hi_nib_d     = hi_nib_q;
      lo_nib_d     = lo_nib_q;
      rs_d         = rs_q;
      emit_d       = 1'b0;
      inc_d        = inc_q;
      cursor_d     = cursor_q;
      cmd_d        = cmd_q;
      data_d       = data_q;
      cmd_valid_d  = 1'b0;
      data_valid_d = 1'b0;
      err_d        = err_q;
      init_done_d  = init_done_q;

      // E-high length; holds the completed high time in the fall cycle
      if (s_e) begin
         e_cnt_d = (e_cnt_q == CNT_MAX) ? e_cnt_q : e_cnt_q + 1'b1;
      end

      if (strobe && s_rw) begin
         err_d[2] = 1'b1;
      end

      if (wr_strobe) begin
         if (e_cnt_q < EHIGH_W) begin
            err_d[0] = 1'b1;
         end
         gap_cnt_d = '0;
         unique case (state_q)
            ST_INIT0: if (s_dat == 4'h3) state_d = ST_INIT1;
            ST_INIT1: if (s_dat == 4'h3) state_d = ST_INIT2;
            ST_INIT2: if (s_dat == 4'h3) state_d = ST_INIT3;
            ST_INIT3: begin
               if (s_dat == 4'h2) begin
                  state_d     = ST_HI;
                  init_done_d = 1'b1;
               end
            end
            ST_HI: begin
               if (gap_cnt_q < gap_req_q) begin
                  err_d[1] = 1'b1;
               end
               hi_nib_d = s_dat;
               rs_d     = s_rs;
               state_d  = ST_LO;
            end
            ST_LO: begin
               if (gap_cnt_q < NIBGAP_W) begin
                  err_d[1] = 1'b1;
               end
               lo_nib_d = s_dat;
               emit_d   = 1'b1;
               state_d  = ST_HI;
            end
            default: state_d = ST_INIT0;
         endcase
      end

      // Byte completion is handled one cycle after the LO capture so the
      // valid pulse, the byte and the cursor all change together.
      if (emit_q) begin
         gap_req_d = BYTE_W;
         if (rs_q) begin
            data_d       = byte_w;
            data_valid_d = 1'b1;
            cursor_d     = inc_q ? cursor_q + 7'd1 : cursor_q - 7'd1;
         end else begin
            cmd_d       = byte_w;
            cmd_valid_d = 1'b1;
            if (byte_w == 8'h01) begin
               cursor_d  = 7'd0;
               inc_d     = 1'b1;
               gap_req_d = CLEAR_W;
            end else if (byte_w == 8'h02 || byte_w == 8'h03) begin
               cursor_d  = 7'd0;
               gap_req_d = CLEAR_W;
            end else if (byte_w[7]) begin
               cursor_d = byte_w[6:0];
            end else if (byte_w[7:2] == 6'b000001) begin
               inc_d = byte_w[1];
            end
         end
      end
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         sync1_q      <= '0;
         sync2_q      <= '0;
         e_dly_q      <= 1'b0;
         e_cnt_q      <= '0;
         gap_cnt_q    <= CNT_MAX;
         gap_req_q    <= BYTE_W;
         state_q      <= ST_INIT0;
         hi_nib_q     <= '0;
         lo_nib_q     <= '0;
         rs_q         <= 1'b0;
         emit_q       <= 1'b0;
         inc_q        <= 1'b1;
         cursor_q     <= '0;
         cmd_q        <= '0;
         data_q       <= '0;
         cmd_valid_q  <= 1'b0;
         data_valid_q <= 1'b0;
         err_q        <= '0;
         init_done_q  <= 1'b0;
      end else begin
         sync1_q      <= sync1_d;
         sync2_q      <= sync2_d;
         e_dly_q      <= e_dly_d;
         e_cnt_q      <= e_cnt_d;
         gap_cnt_q    <= gap_cnt_d;
         gap_req_q    <= gap_req_d;
         state_q      <= state_d;
         hi_nib_q     <= hi_nib_d;
         lo_nib_q     <= lo_nib_d;
         rs_q         <= rs_d;
         emit_q       <= emit_d;
         inc_q        <= inc_d;
         cursor_q     <= cursor_d;
         cmd_q        <= cmd_d;
         data_q       <= data_d;
         cmd_valid_q  <= cmd_valid_d;
         data_valid_q <= data_valid_d;
         err_q        <= err_d;
         init_done_q  <= init_done_d;
      end
   end

   assign oInitDone     = init_done_q;
   assign oCommandValid = cmd_valid_q;
   assign oCommand      = cmd_q;
   assign oDataValid    = data_valid_q;
   assign oData         = data_q;
   assign oCursorAddr   = cursor_q;
   assign oErrorFlags   = err_q;

endmodule

// File: tb/tb_lcd_hd44780_receiver.sv
// tb/tb_lcd_hd44780_receiver.sv - self-checking bench for lcd_hd44780_receiver
module tb_lcd_hd44780_receiver;
   localparam int EH = 12;
   localparam int NG = 50;
   localparam int BG = 200;
   localparam int CG = 2000;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       init_done, cmd_valid, data_valid;
   logic [7:0] cmd, data;
   logic [6:0] cursor;
   logic [2:0] err;
   int         cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   lcd_hd44780_receiver_if lcd ();

   lcd_hd44780_receiver #(
      .MIN_E_HIGH(EH), .MIN_NIBBLE_GAP(NG),
      .MIN_BYTE_GAP(BG), .MIN_CLEAR_GAP(CG)
   ) u_dut (
      .Clock(clk), .Reset(rst_n), .lcd(lcd),
      .oInitDone(init_done), .oCommandValid(cmd_valid), .oCommand(cmd),
      .oDataValid(data_valid), .oData(data), .oCursorAddr(cursor),
      .oErrorFlags(err)
   );

   // Observed traffic
   logic [7:0]  obs_cmd[$];
   logic [14:0] obs_data[$];
   int          both_hi = 0, cmdv_cycles = 0, datv_cycles = 0, last_dv_cyc = -1;

   always @(negedge clk) begin
      if (rst_n) begin
         if (cmd_valid) begin
            obs_cmd.push_back(cmd);
            cmdv_cycles++;
         end
         if (data_valid) begin
            obs_data.push_back({data, cursor});
            datv_cycles++;
            last_dv_cyc = cyc;
         end
         if (cmd_valid && data_valid) both_hi++;
      end
   end

   // Reference model: the receiver described as init progress, a byte phase,
   // a cursor and the gap rules, advanced once per strobe.
   int          m_init, m_req, m_ncmd = 0, m_ndat = 0;
   bit          m_lo, m_rs, m_inc;
   bit [3:0]    m_hi;
   bit [6:0]    m_cur;
   bit [2:0]    m_err;
   longint      m_last_fall;
   bit [7:0]    exp_cmd[$];
   bit [14:0]   exp_data[$];
   int          last_fall;

   int passed = 0, total = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total = total + 1;
      assert (obs === expv) passed = passed + 1;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      m_init = 0; m_lo = 0; m_rs = 0; m_hi = 0; m_cur = 0; m_inc = 1;
      m_err = 0; m_req = BG; m_last_fall = -1000000;
      exp_cmd.delete(); exp_data.delete();
      obs_cmd.delete(); obs_data.delete();
   endtask

   task automatic model_strobe(input bit sf, input bit rw, input bit rs,
                               input bit [3:0] d, input int ehigh, input int fall);
      longint gap;
      bit [7:0] b;
      if (!sf) return;
      if (rw) begin
         m_err[2] = 1;
         return;
      end
      if (ehigh < EH) m_err[0] = 1;
      gap = fall - m_last_fall;
      m_last_fall = fall;
      if (m_init < 4) begin
         if (d == ((m_init == 3) ? 4'h2 : 4'h3)) m_init++;
      end else if (!m_lo) begin
         if (gap < m_req) m_err[1] = 1;
         m_hi = d; m_rs = rs; m_lo = 1;
      end else begin
         if (gap < NG) m_err[1] = 1;
         m_lo = 0;
         b = {m_hi, d};
         m_req = BG;
         if (m_rs) begin
            m_cur = m_inc ? m_cur + 1 : m_cur - 1;
            exp_data.push_back({b, m_cur});
            m_ndat++;
         end else begin
            exp_cmd.push_back(b);
            m_ncmd++;
            if (b == 8'h01) begin
               m_cur = 0; m_inc = 1; m_req = CG;
            end else if (b == 8'h02 || b == 8'h03) begin
               m_cur = 0; m_req = CG;
            end else if (b >= 8'h80) begin
               m_cur = b[6:0];
            end else if (b >= 8'h04 && b <= 8'h07) begin
               m_inc = b[1];
            end
         end
      end
   endtask

   task automatic send_nibble(input bit sf, input bit rw, input bit rs,
                              input bit [3:0] d, input int ehigh, input int pre);
      tick(pre);
      lcd.iLCD_StrataFlashControl = sf;
      lcd.iLCD_ReadWrite = rw;
      lcd.iLCD_RegisterSelect = rs;
      lcd.iLCD_Data = d;
      tick(3);
      lcd.iLCD_Enabled = 1'b1;
      tick(ehigh);
      lcd.iLCD_Enabled = 1'b0;
      last_fall = cyc;
      tick(4);
      model_strobe(sf, rw, rs, d, ehigh, last_fall);
   endtask

   task automatic send_byte(input bit rs, input bit [7:0] b, input int hi_pre,
                            input int lo_pre, input int hi_eh);
      send_nibble(1, 0, rs, b[7:4], hi_eh, hi_pre);
      send_nibble(1, 0, rs, b[3:0], 20, lo_pre);
      tick(2);
   endtask

   task automatic byte_ok(input bit rs, input bit [7:0] b);
      send_byte(rs, b, m_req + 20, NG + 20, 20);
   endtask

   task automatic do_init();
      send_nibble(1, 0, 0, 4'h3, 20, 50);
      send_nibble(1, 0, 0, 4'h3, 20, 50);
      send_nibble(1, 0, 0, 4'h3, 20, 50);
      send_nibble(1, 0, 0, 4'h2, 20, 50);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      lcd.iLCD_Enabled = 1'b0;
      tick(3);
      model_reset();
      rst_n = 1'b1;
      tick(2);
   endtask

   task automatic check_state(input string tag);
      check({tag, ".ncmd"}, obs_cmd.size(), exp_cmd.size());
      for (int i = 0; i < exp_cmd.size() && i < obs_cmd.size(); i++)
         check({tag, ".cmd"}, {24'd0, obs_cmd[i]}, {24'd0, exp_cmd[i]});
      check({tag, ".ndat"}, obs_data.size(), exp_data.size());
      for (int i = 0; i < exp_data.size() && i < obs_data.size(); i++)
         check({tag, ".data_cur"}, {17'd0, obs_data[i]}, {17'd0, exp_data[i]});
      check({tag, ".cursor"}, {25'd0, cursor}, {25'd0, m_cur});
      check({tag, ".err"}, {29'd0, err}, {29'd0, m_err});
      check({tag, ".init"}, {31'd0, init_done}, {31'd0, (m_init == 4)});
      obs_cmd.delete(); obs_data.delete();
      exp_cmd.delete(); exp_data.delete();
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, ".init"}, {31'd0, init_done}, 0);
      check({tag, ".cmdv"}, {31'd0, cmd_valid}, 0);
      check({tag, ".datv"}, {31'd0, data_valid}, 0);
      check({tag, ".cmd"}, {24'd0, cmd}, 0);
      check({tag, ".data"}, {24'd0, data}, 0);
      check({tag, ".cursor"}, {25'd0, cursor}, 0);
      check({tag, ".err"}, {29'd0, err}, 0);
   endtask

   initial begin
      bit rs;
      bit [7:0] b;
      int hp, lp, eh;
      lcd.iLCD_Enabled = 1'b0;
      lcd.iLCD_RegisterSelect = 1'b0;
      lcd.iLCD_StrataFlashControl = 1'b1;
      lcd.iLCD_ReadWrite = 1'b0;
      lcd.iLCD_Data = 4'h0;
      do_reset();
      check_reset_values("reset");

      // Init handshake and function set
      send_nibble(1, 0, 0, 4'h3, 20, 50);
      send_nibble(1, 0, 0, 4'h3, 20, 50);
      send_nibble(1, 0, 0, 4'h3, 20, 50);
      check("init_pending", {31'd0, init_done}, 0);
      send_nibble(1, 0, 0, 4'h2, 20, 50);
      check("init_done", {31'd0, init_done}, 1);
      byte_ok(0, 8'h28);
      check("fs_cmd", {24'd0, cmd}, 32'h28);
      check("fs_err", {29'd0, err}, 0);
      check_state("fs");

      // Data write with output latency
      byte_ok(1, 8'h41);
      check("dw_latency", last_dv_cyc - last_fall, 4);
      check("dw_cursor", {25'd0, cursor}, 32'h01);
      check_state("dw");

      // Address set and wrap in both directions
      byte_ok(0, 8'hFF);
      check("addr_ff", {25'd0, cursor}, 32'h7F);
      byte_ok(1, 8'h20);
      check("wrap_up", {25'd0, cursor}, 32'h00);
      byte_ok(0, 8'h04);
      byte_ok(1, 8'h20);
      check("wrap_down", {25'd0, cursor}, 32'h7F);
      check_state("wrap");

      // Short E pulse, nibble still accepted
      send_byte(0, 8'h06, m_req + 20, NG + 20, 5);
      check("short_e", {31'd0, err[0]}, 1);
      check_state("short");

      // Clear followed by only a normal byte gap
      byte_ok(0, 8'h01);
      send_byte(1, 8'h33, BG + 20, NG + 20, 20);
      check("clear_gap_bad", {31'd0, err[1]}, 1);
      check_state("clr_bad");

      // Clear followed by a full clear gap, from a fresh reset
      do_reset();
      do_init();
      byte_ok(0, 8'h01);
      send_byte(1, 8'h34, CG + 20, NG + 20, 20);
      check("clear_gap_ok", {29'd0, err}, 0);
      check_state("clr_ok");

      // Reset mid-byte
      send_nibble(1, 0, 1, 4'h4, 20, BG + 20);
      rst_n = 1'b0;
      tick(2);
      check_reset_values("mid_reset");
      model_reset();
      rst_n = 1'b1;
      tick(2);
      send_nibble(1, 0, 0, 4'h2, 20, 50);
      send_nibble(1, 0, 0, 4'h3, 20, 50);
      send_nibble(1, 0, 0, 4'h3, 20, 50);
      check("reinit_pending", {31'd0, init_done}, 0);
      send_nibble(1, 0, 0, 4'h3, 20, 50);
      send_nibble(1, 0, 0, 4'h2, 20, 50);
      check("reinit_done", {31'd0, init_done}, 1);
      byte_ok(1, 8'h42);
      check_state("reinit");

      // Strobes without bus ownership are ignored
      send_nibble(0, 0, 1, 4'h5, 5, 50);
      send_nibble(0, 1, 1, 4'h5, 20, 50);
      send_nibble(0, 0, 0, 4'h1, 20, 50);
      check("sf0_err", {29'd0, err}, 0);
      byte_ok(1, 8'h55);
      check_state("sf0");

      // Read attempt
      send_nibble(1, 1, 0, 4'h3, 20, 50);
      check("rw_flag", {31'd0, err[2]}, 1);
      byte_ok(1, 8'h66);
      check_state("rw");

      // Randomized bytes with occasional timing violations
      for (int i = 0; i < 12; i++) begin
         rs = 1'($urandom_range(0, 1));
         b  = 8'($urandom);
         hp = ($urandom_range(0, 3) == 0) ? 10 : m_req + 20;
         lp = ($urandom_range(0, 3) == 0) ? 5 : NG + 20;
         eh = ($urandom_range(0, 3) == 0) ? 6 : 20;
         send_byte(rs, b, hp, lp, eh);
         check_state("rand");
      end

      tick(5);
      check("both_valid", both_hi, 0);
      check("cmd_pulses", cmdv_cycles, m_ncmd);
      check("data_pulses", datv_cycles, m_ndat);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/lcd_hd44780_receiver.md
# lcd_hd44780_receiver

Bus-functional receiver for the 4-bit HD44780 character-LCD interface: it sits on the far end of the LCD control lines and behaves as the display controller. It samples the enable, register-select, read/write, StrataFlash-control and 4-bit data lines, runs the 4-bit power-on init handshake, and reassembles nibbles into bytes. It decodes commands, tracks the DDRAM cursor, and flags timing violations. It is used both as a synthesizable loop-back checker and as the self-checking end of the LCD controller's testbench.

## Interface
- MIN_E_HIGH, 12, minimum Clock cycles the synchronized enable must stay high (240 ns at 50 MHz)
- MIN_NIBBLE_GAP, 50, minimum cycles between the high-nibble and low-nibble enable falling edges of one byte
- MIN_BYTE_GAP, 2000, minimum cycles from the previous byte's completion to the next byte's high-nibble falling edge
- MIN_CLEAR_GAP, 82000, same as MIN_BYTE_GAP, but applies after a clear (0x01) or home (0x02/0x03) command
- Clock  in  1  system clock
- Reset  in  1  asynchronous, active-low reset
- iLCD_Enabled  in  1  LCD E strobe, asynchronous to Clock
- iLCD_RegisterSelect  in  1  0 = command, 1 = data
- iLCD_StrataFlashControl  in  1  must be 1 for the LCD to own the bus
- iLCD_ReadWrite  in  1  0 = write, 1 = read
- iLCD_Data  in  4  data nibble
- oInitDone  out  1  high once the init sequence has completed
- oCommandValid  out  1  one-cycle pulse; oCommand is valid
- oCommand  out  8  last decoded command byte
- oDataValid  out  1  one-cycle pulse; oData is valid
- oData  out  8  last data byte
- oCursorAddr  out  7  current DDRAM address
- oErrorFlags  out  3  sticky flags: [0] short E pulse, [1] gap violation, [2] read attempted

## Operation
- All iLCD_* inputs pass through a 2-flop synchronizer. An enable falling edge is detected when the delayed synchronized E is 1 and the synchronized E is 0.
- A falling edge is a valid strobe only when iLCD_StrataFlashControl=1. Strobes with StrataFlashControl=0 are ignored entirely: no state change and no flags.
- A valid strobe with iLCD_ReadWrite=1 sets oErrorFlags[2] and is otherwise ignored.
- E-high counter:
  - Counts cycles while the synchronized E is 1.
  - At each valid falling edge, a count below MIN_E_HIGH sets oErrorFlags[0]; the nibble is still accepted.
- State machine:
  - States: INIT0 → INIT1 → INIT2 → INIT3 → HI → LO → HI …
  - INIT0–INIT2 each advance on a write strobe with nibble 0x3.
  - INIT3 advances on nibble 0x2 and sets oInitDone.
  - Any other nibble in an INIT state leaves the state unchanged.
  - No gap checks apply during INIT.
- Byte assembly:
  - In HI, the nibble becomes byte[7:4] and RS is latched.
  - In LO, the nibble becomes byte[3:0]; the byte is then emitted using the RS latched in HI.
- Command decode (RS=0). oCommand is loaded and oCommandValid pulses. Effects:
  - 0x01 clear: cursor := 0, increment mode := 1, next gap requirement := MIN_CLEAR_GAP.
  - 0x02/0x03 home: cursor := 0, next gap requirement := MIN_CLEAR_GAP.
  - 0x04–0x07 entry mode: increment := bit1.
  - 0x80–0xFF set DDRAM address: cursor := byte[6:0].
  - All other commands: no state effect, next gap requirement := MIN_BYTE_GAP.
- Data write (RS=1): oData is loaded and oDataValid pulses. The cursor moves +1 if increment=1, else −1, modulo 128 (0x7F+1 → 0x00, 0x00−1 → 0x7F).
- Gap counter:
  - Counts cycles since the last nibble strobe and saturates at 2^17−1.
  - At the LO strobe, a count below MIN_NIBBLE_GAP sets oErrorFlags[1].
  - At the HI strobe, a count below the current gap requirement sets oErrorFlags[1].
  - Offending nibbles are still accepted.
- oErrorFlags clear only on reset.

## Timing
- Reset values:
  - oInitDone=0, oCommandValid=0, oDataValid=0
  - oCommand=0x00, oData=0x00, oCursorAddr=0x00, oErrorFlags=3'b000
  - State=INIT0, increment mode=1
  - Gap requirement=MIN_BYTE_GAP; gap counter saturated, so the first HI after init passes.
- Detection latency: a falling edge first sampled low at rising edge k is detected at edge k+2.
- Capture and output: the nibble is captured at edge k+2. For a LO strobe, the Valid pulse, oCommand/oData and oCursorAddr all update at edge k+3.
- Driver requirement: iLCD_Data, RS and RW must be stable from 3 cycles before to 3 cycles after the E falling edge.
- oCommandValid and oDataValid are never high in the same cycle. Each is high for exactly 1 cycle per byte.
- Reset asserted mid-byte (state LO) discards the half-byte and returns to INIT0. The receiver requires a full init again.

## Test plan
- Init and function set: nibbles 3,3,3,2, then byte 0x28 (RS=0), all gaps legal. Expect oInitDone=1 and one oCommandValid with oCommand=0x28; oErrorFlags=0.
- Data write: after init, RS=1 byte 0x41 with cursor 0. Expect oDataValid pulse, oData=0x41, oCursorAddr 0x00→0x01 in the same cycle.
- Address set and wrap: command 0xFF gives cursor 0x7F; data byte 0x20 gives cursor 0x00. Then entry command 0x04 and data 0x20 give cursor 0x7F.
- Short strobe: E high for 5 cycles on a legal nibble. Expect oErrorFlags[0]=1 and the nibble still accepted.
- Clear gap: command 0x01, then the next byte 2000 cycles later. Expect oErrorFlags[1]=1. Repeat with 82000 cycles after reset and expect 0.
- Reset and bus ownership:
  - Reset asserted after the HI nibble: expect all outputs at reset values and state INIT0.
  - Strobes with StrataFlashControl=0: ignored.
  - Strobe with RW=1: sets oErrorFlags[2].
